// File: rtl/uart_msg_pkg.sv
// Shared state encoding, ASCII constants and byte helpers for the UART message controller.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) ? (b - CASE_OFFSET) : b;
  endfunction

endpackage

// File: rtl/uart_msg_fifo.sv
// Synchronous echo FIFO with first-word-fall-through head; a push is accepted
// when full if a pop happens in the same cycle.
module uart_msg_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_msg_ctrl.sv
// Periodic UART message sender with an rx echo path drained between messages.
// Optional macro UART_MSG_ECHO_UPPER_EN upper-cases echoed ASCII letters.
module uart_msg_ctrl
  import uart_msg_pkg::*;
#(
  parameter int                   MSG_LEN     = 13,
  parameter logic [MSG_LEN*8-1:0] MSG         = {"HELLO GOWIN", ASCII_CR, ASCII_LF},
  parameter int                   WAIT_CYCLES = 50_000_000,
  parameter int                   FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  input  logic        msg_trigger,
  output logic        overflow,
  output logic [15:0] msg_count
);

  state_t      state;
  state_t      next_state;
  logic [7:0]  byte_idx;
  logic [7:0]  next_idx;
  logic [7:0]  next_tx_data;
  logic        next_valid;
  logic [31:0] wait_cnt;
  logic [31:0] next_wait;
  logic [15:0] next_count;

  logic        handshake;
  logic        last_byte;
  logic        timeout;
  logic        go_send;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [7:0]  echo_byte;

  function automatic logic [7:0] msg_byte(input logic [7:0] idx);
    return MSG[8*(MSG_LEN-1-int'(idx)) +: 8];
  endfunction

  assign rx_data_ready = 1'b1;
  assign handshake     = tx_data_valid && tx_data_ready;
  assign last_byte     = (byte_idx == 8'(MSG_LEN-1));
  assign timeout       = (wait_cnt >= 32'(WAIT_CYCLES-1));
  assign go_send       = (state == WAIT) && !tx_data_valid && (timeout || msg_trigger);
  // A resend always waits for an idle tx slot, so the echo path only pops when not leaving.
  assign fifo_pop      = (state == WAIT) && !fifo_empty &&
                         (handshake || (!tx_data_valid && !go_send));

`ifdef UART_MSG_ECHO_UPPER_EN
  assign echo_byte = to_upper(fifo_dout);
`else
  assign echo_byte = fifo_dout;
`endif

  uart_msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_data_valid),
    .din   (rx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    next_state   = state;
    next_idx     = byte_idx;
    next_tx_data = tx_data;
    next_valid   = tx_data_valid;
    next_wait    = wait_cnt;
    next_count   = msg_count;
    case (state)
      IDLE: begin
        next_state = SEND;
        next_idx   = 8'd0;
      end
      SEND: begin
        if (!tx_data_valid) begin
          next_tx_data = msg_byte(byte_idx);
          next_valid   = 1'b1;
        end else if (handshake) begin
          if (last_byte) begin
            next_valid = 1'b0;
            next_wait  = 32'd0;
            next_count = msg_count + 16'd1;
            next_state = WAIT;
          end else begin
            next_idx     = byte_idx + 8'd1;
            next_tx_data = msg_byte(byte_idx + 8'd1);
          end
        end
      end
      WAIT: begin
        next_wait = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;
        if (go_send) begin
          next_state = SEND;
          next_idx   = 8'd0;
        end else if (fifo_pop) begin
          next_tx_data = echo_byte;
          next_valid   = 1'b1;
        end else if (handshake) begin
          next_valid = 1'b0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_idx      <= 8'd0;
      tx_data       <= 8'd0;
      tx_data_valid <= 1'b0;
      wait_cnt      <= 32'd0;
      msg_count     <= 16'd0;
      overflow      <= 1'b0;
    end else begin
      state         <= next_state;
      byte_idx      <= next_idx;
      tx_data       <= next_tx_data;
      tx_data_valid <= next_valid;
      wait_cnt      <= next_wait;
      msg_count     <= next_count;
      overflow      <= rx_data_valid && fifo_full && !fifo_pop;
    end
  end

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Directed scoreboard bench for uart_msg_ctrl (MSG "AB"+CR LF, 100-cycle wait, 4-deep FIFO).
// Honours UART_MSG_ECHO_UPPER_EN for the expected echo of a lower-case byte.
module tb_uart_msg_ctrl;

  localparam int MSG_LEN     = 4;
  localparam int WAIT_CYCLES = 100;
  localparam int FIFO_DEPTH  = 4;

  typedef struct {
    logic [7:0] data;
    int         rel;
  } rx_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        msg_trigger;
  logic        overflow;
  logic [15:0] msg_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         base = 0;
  int         ovf_cnt = 0;
  int         model_cnt = 0;
  rx_t        got_q[$];
  logic [7:0] exp_q[$];

  uart_msg_ctrl #(
    .MSG_LEN     (MSG_LEN),
    .MSG         ({"AB", 8'h0d, 8'h0a}),
    .WAIT_CYCLES (WAIT_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .msg_trigger   (msg_trigger),
    .overflow      (overflow),
    .msg_count     (msg_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle numbering is relative to reset release: the first cycle after release is 1.
  always @(negedge clk) begin
    if (rst_n && tx_data_valid && tx_data_ready) begin
      rx_t e;
      e.data = tx_data;
      e.rel  = cyc - base;
      got_q.push_back(e);
    end
    if (overflow) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one rx strobe; the expectation is queued only if the modelled FIFO has room.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    if (model_cnt < FIFO_DEPTH) begin
      exp_q.push_back(b);
      model_cnt++;
    end
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic waitRx(input string tag, input int n);
    int budget = 0;
    while (got_q.size() < n && budget < 400) begin
      @(negedge clk); #1;
      budget++;
    end
    checkOutput(tag, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic scoreCheck(input string tag, output int rel);
    logic [7:0] obs = 8'hxx;
    logic [7:0] expv = 8'hxx;
    rel = -1;
    if (got_q.size() > 0) begin
      rx_t e = got_q.pop_front();
      obs = e.data;
      rel = e.rel;
    end
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    checkOutput(tag, 32'(obs), 32'(expv));
  endtask

  task automatic pushMsg();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endtask

  initial begin
    int rel;
    int s_a;
    int s_b;
    int s_0a;
    int hold_start;
    int trig_rel;
    int guard;
    logic [7:0] lower_echo;

    rst_n = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0;
    tx_data_ready = 1'b1; msg_trigger = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(tx_data_valid), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_count", 32'(msg_count), 32'd0);
    checkOutput("rx_ready", 32'(rx_data_ready), 32'd1);

    // Message on cycles 3..6, then WAIT for WAIT_CYCLES cycles and one SEND cycle.
    @(posedge clk); #1;
    base = cyc - 1;
    rst_n = 1'b1;
    pushMsg();
    exp_q.push_back(8'h41);
    waitRx("p1_wait", 5);
    for (int i = 0; i < 5; i++) begin
      scoreCheck("p1_byte", rel);
      if (i < 4) checkOutput("p1_cycle", 32'(rel), 32'(3 + i));
      else       checkOutput("p1_resend_cycle", 32'(rel), 32'(6 + WAIT_CYCLES + 2));
    end
    checkOutput("p1_count", 32'(msg_count), 32'd1);

    // Back-pressure on byte 42.
    @(posedge clk); #1;
    tx_data_ready = 1'b0;
    hold_start = cyc - base;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("p2_hold_valid", 32'(tx_data_valid), 32'd1);
      checkOutput("p2_hold_data", 32'(tx_data), 32'h42);
    end
    @(posedge clk); #1;
    tx_data_ready = 1'b1;
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
    waitRx("p2_wait", 3);
    scoreCheck("p2_byte42", rel);
    checkOutput("p2_cycle42", 32'(rel), 32'(hold_start + 5));
    scoreCheck("p2_byte0d", rel);
    scoreCheck("p2_byte0a", rel);

    // Echo in WAIT with the first echo still in flight at timeout.
    @(posedge clk); #1;
    tx_data_ready = 1'b0;
    model_cnt = 0;
    applyStimulus(8'h31);
    applyStimulus(8'h32);
    applyStimulus(8'h33);
    exp_q.push_back(8'h41);
    repeat (120) @(posedge clk);
    @(negedge clk);
    checkOutput("p3_inflight_valid", 32'(tx_data_valid), 32'd1);
    checkOutput("p3_inflight_data", 32'(tx_data), 32'h31);
    @(posedge clk); #1;
    tx_data_ready = 1'b1;
    waitRx("p3_wait", 4);
    scoreCheck("p3_echo31", s_a);
    scoreCheck("p3_echo32", s_b);
    checkOutput("p3_b2b_32", 32'(s_b - s_a), 32'd1);
    scoreCheck("p3_echo33", s_a);
    checkOutput("p3_b2b_33", 32'(s_a - s_b), 32'd1);
    scoreCheck("p3_resend41", s_b);
    checkOutput("p3_resend_gap", 32'(s_b - s_a), 32'd3);

    // Overflow: six rx bytes while SEND is stalled on byte 42.
    @(posedge clk); #1;
    tx_data_ready = 1'b0;
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
    model_cnt = 0;
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) applyStimulus(8'h50 + 8'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("p4_overflow_pulses", 32'(ovf_cnt), 32'd2);
    @(posedge clk); #1;
    tx_data_ready = 1'b1;
    waitRx("p4_wait", 7);
    scoreCheck("p4_byte42", rel);
    scoreCheck("p4_byte0d", rel);
    scoreCheck("p4_byte0a", s_0a);
    for (int i = 0; i < 4; i++) scoreCheck("p4_echo", rel);
    checkOutput("p4_count", 32'(msg_count), 32'd3);

    // Trigger at WAIT cycle 10 with an empty FIFO.
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((cyc - base) < (s_0a + 11) && guard < 200);
    msg_trigger = 1'b1;
    trig_rel = cyc - base;
    @(posedge clk); #1;
    msg_trigger = 1'b0;
    pushMsg();
    waitRx("p5_wait", 4);
    scoreCheck("p5_byte41", rel);
    checkOutput("p5_trig_latency", 32'(rel), 32'(trig_rel + 2));
    for (int i = 0; i < 3; i++) scoreCheck("p5_msg", rel);
`ifdef UART_MSG_ECHO_UPPER_EN
    lower_echo = 8'h41;
`else
    lower_echo = 8'h61;
`endif
    @(posedge clk); #1;
    model_cnt = 0;
    rx_data = 8'h61;
    rx_data_valid = 1'b1;
    exp_q.push_back(lower_echo);
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
    waitRx("p5_echo_wait", 1);
    scoreCheck("p5_echo_case", rel);
    checkOutput("p5_count", 32'(msg_count), 32'd4);

    // Reset in the middle of a message while byte 0D is presented.
    @(posedge clk); #1;
    msg_trigger = 1'b1;
    @(posedge clk); #1;
    msg_trigger = 1'b0;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    waitRx("p6_wait", 2);
    scoreCheck("p6_byte41", rel);
    scoreCheck("p6_byte42", rel);
    @(posedge clk); #1;
    tx_data_ready = 1'b0;
    @(negedge clk); #1;
    checkOutput("p6_pre_data", 32'(tx_data), 32'h0d);
    rst_n = 1'b0;
    #1;
    checkOutput("p6_rst_valid", 32'(tx_data_valid), 32'd0);
    checkOutput("p6_rst_data", 32'(tx_data), 32'd0);
    checkOutput("p6_rst_count", 32'(msg_count), 32'd0);
    tx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    base = cyc - 1;
    rst_n = 1'b1;
    pushMsg();
    waitRx("p6_restart_wait", 4);
    for (int i = 0; i < 4; i++) begin
      scoreCheck("p6_restart_byte", rel);
      checkOutput("p6_restart_cycle", 32'(rel), 32'(3 + i));
    end
    checkOutput("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_msg_ctrl.md
UART_MSG_CTRL -- requirements
Module: uart_msg_ctrl

Interface
REQ-001 SHALL have parameter MSG_LEN, default 13, meaning number of message bytes (1..255).
REQ-002 SHALL have parameter MSG, default "HELLO GOWIN" followed by 16'h0d0a, meaning MSG_LEN*8-bit message; byte 0 is the most significant byte.
REQ-003 SHALL have parameter WAIT_CYCLES, default 50_000_000, meaning clk cycles spent in WAIT before resend (>=2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning echo FIFO depth (power of two, >=2).
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port rx_data, input, 8 bits: received byte from uart_rx.
REQ-008 SHALL have port rx_data_valid, input, 1 bit: one-cycle strobe, rx_data valid.
REQ-009 SHALL have port rx_data_ready, output, 1 bit: tied 1 (uart_rx cannot stall).
REQ-010 SHALL have port tx_data, output, 8 bits: byte to uart_tx.
REQ-011 SHALL have port tx_data_valid, output, 1 bit: tx_data valid.
REQ-012 SHALL have port tx_data_ready, input, 1 bit: uart_tx accepts the byte.
REQ-013 SHALL have port msg_trigger, input, 1 bit: request immediate message resend.
REQ-014 SHALL have port overflow, output, 1 bit: one-cycle pulse, echo byte dropped.
REQ-015 SHALL have port msg_count, output, 16 bits: completed messages, wraps at 16'hFFFF->0.

Function
REQ-016 SHALL implement states IDLE, SEND and WAIT: IDLE->SEND unconditionally; SEND->WAIT after the last-byte handshake; WAIT->SEND on timeout or trigger (REQ-022, REQ-023).
REQ-017 SHALL treat a handshake as tx_data_valid&&tx_data_ready on a rising edge; while valid=1 and no handshake, tx_data and tx_data_valid SHALL hold stable.
REQ-018 SHALL, in SEND, present byte 0 with valid=1 on the cycle after entering SEND; on each handshake of byte i<MSG_LEN-1, SHALL present byte i+1 on the next cycle with valid held at 1.
REQ-019 SHALL, on the handshake of byte MSG_LEN-1, drop valid, clear wait_cnt, increment msg_count, and enter WAIT.
REQ-020 SHALL push every rx_data_valid byte into the echo FIFO in any state when not full; when full, SHALL drop the byte and pulse overflow for 1 cycle.
REQ-021 SHALL, in WAIT, pop the FIFO head into tx_data with valid=1 when valid=0 and not empty; on a handshake, SHALL load the next entry back-to-back if not empty, else drop valid.
REQ-022 SHALL increment wait_cnt every WAIT cycle and enter SEND when wait_cnt>=WAIT_CYCLES-1 and tx_data_valid=0; an in-flight echo byte SHALL complete first.
REQ-023 SHALL treat msg_trigger=1 in WAIT with tx_data_valid=0 as an immediate timeout; SHALL ignore msg_trigger in IDLE and SEND.
REQ-024 SHALL accept a simultaneous push and pop (count unchanged), including when full; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 SHALL retain FIFO contents across SEND and drain them in the next WAIT.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, tx_data=0, tx_data_valid=0, overflow=0, msg_count=0, wait_cnt=0, and FIFO empty, regardless of any transfer in progress.
REQ-027 SHALL, after rst_n deasserts, follow IDLE (cycle 1) -> SEND (cycle 2) -> byte 0 valid (cycle 3).

Configuration
REQ-028 SHALL, with macro UART_MSG_ECHO_UPPER_EN defined, convert echoed bytes 8'h61..8'h7A to uppercase (minus 8'h20) at FIFO pop; without it, SHALL echo bytes unmodified; message bytes are never converted.

Structure
REQ-029 SHALL place state encoding (IDLE=0, SEND=1, WAIT=2) and ASCII constants (CR, LF, case offset 8'h20) in shared package uart_msg_pkg.
REQ-030 SHALL implement the echo FIFO as sub-module uart_msg_fifo (synchronous, parameter DEPTH, with full/empty flags).

Verification (bench: MSG_LEN=4, MSG="AB"+0d0a, WAIT_CYCLES=100, FIFO_DEPTH=4)
REQ-031 SHALL cover: tx_data_ready always 1 after reset -> bytes 41,42,0D,0A on cycles 3..6, msg_count=1, WAIT entered; the next byte 41 appears 100 cycles later.
REQ-032 SHALL cover: tx_data_ready low 5 cycles during byte 42 -> tx_data holds 42 with valid=1, no byte is skipped.
REQ-033 SHALL cover: in WAIT, rx bytes 31,32,33 -> echoed 31,32,33 in order; the WAIT->SEND transition is delayed until the last echo handshake.
REQ-034 SHALL cover: 6 rx bytes during SEND with FIFO_DEPTH=4 -> overflow pulses twice, first 4 bytes echoed in the next WAIT.
REQ-035 SHALL cover: msg_trigger pulse at WAIT cycle 10 with FIFO empty -> byte 41 valid 2 cycles later; with UART_MSG_ECHO_UPPER_EN, rx 61 -> echo 41.
REQ-036 SHALL cover: rst_n low mid-message at byte 0D -> valid=0 immediately, msg_count=0, message restarts at 41 on cycle 3.
